life_sequencer: RTL and testbench

LIFE_SEQUENCER -- requirements
Module: life_sequencer

---
 rtl/life_sequencer.sv | 80 ++++++++
 tb/tb_life_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/life_sequencer.sv
// life_sequencer: load/step/free-run control of an 8x8 Life grid with extinction, still-life and period-2 halt detection.
module life_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] seed,
  input  logic        load,
  input  logic        run,
  input  logic        step,
  input  logic [3:0]  rate,
  input  logic [63:0] next_grid,
  output logic [63:0] grid,
  output logic [15:0] gen_count,
  output logic [1:0]  state,
  output logic        evolve,
  output logic        extinct,
  output logic        stable,
  output logic        osc2
);
  typedef enum logic [1:0] {IDLE = 2'b00, PAUSED = 2'b01, RUNNING = 2'b10, HALTED = 2'b11} state_t;
  state_t      cur, nxt;
  logic [63:0] prev;
  logic        prev_valid, step_q;
  logic [3:0]  tick, tick_nxt;
  logic        hit_ext, hit_stb, hit_osc;
  assign state = cur;
  always_comb begin
    nxt      = cur;
    evolve   = 1'b0;
    tick_nxt = tick;
    if (load) begin
      nxt      = PAUSED;
      tick_nxt = 4'd0;
    end else if (cur == PAUSED) begin
      nxt    = run ? RUNNING : PAUSED;
      evolve = !run && step && !step_q;
    end else if (cur == RUNNING) begin
      nxt      = run ? RUNNING : PAUSED;
      evolve   = run && tick == rate;
      tick_nxt = (!run || tick == rate) ? 4'd0 : tick + 4'd1;
    end
    hit_ext = next_grid == 64'd0;
    hit_stb = !hit_ext && next_grid == grid;
    hit_osc = !hit_ext && !hit_stb && prev_valid && next_grid == prev;
    if (evolve && (hit_ext || hit_stb || hit_osc)) nxt = HALTED;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= IDLE;
      grid       <= 64'd0;
      prev       <= 64'd0;
      prev_valid <= 1'b0;
      gen_count  <= 16'd0;
      extinct    <= 1'b0;
      stable     <= 1'b0;
      osc2       <= 1'b0;
      tick       <= 4'd0;
      step_q     <= 1'b0;
    end else begin
      cur    <= nxt;
      tick   <= tick_nxt;
      step_q <= step;
      if (load) begin
        grid       <= seed;
        gen_count  <= 16'd0;
        prev_valid <= 1'b0;
        extinct    <= 1'b0;
        stable     <= 1'b0;
        osc2       <= 1'b0;
      end else if (evolve) begin
        prev       <= grid;
        grid       <= next_grid;
        prev_valid <= 1'b1;
        gen_count  <= gen_count + {15'd0, gen_count != 16'hFFFF};
        extinct    <= hit_ext;
        stable     <= hit_stb;
        osc2       <= hit_osc;
      end
    end
  end
endmodule

// File: tb/tb_life_sequencer.sv
// tb_life_sequencer: vector table plus directed sequences against a bounded 8x8 Life model feeding next_grid.
module tb_life_sequencer;
  logic        clk = 1'b0, reset = 1'b1, load = 1'b0, run = 1'b0, step = 1'b0;
  logic [63:0] seed = 64'd0, next_grid, grid;
  logic [3:0]  rate = 4'd0;
  logic [15:0] gen_count;
  logic [1:0]  state;
  logic        evolve, extinct, stable, osc2;
  int checks = 0, failures = 0;

  life_sequencer dut (
    .clk(clk), .reset(reset), .seed(seed), .load(load), .run(run), .step(step),
    .rate(rate), .next_grid(next_grid), .grid(grid), .gen_count(gen_count),
    .state(state), .evolve(evolve), .extinct(extinct), .stable(stable), .osc2(osc2)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    n = 64'd0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              cnt += int'(g[(r + dr) * 8 + c + dc]);
        n[r * 8 + c] = cnt == 3 || (g[r * 8 + c] && cnt == 2);
      end
    return n;
  endfunction

  always_comb next_grid = life(grid);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic l, input logic r, input logic s, input logic [3:0] rt, input logic [63:0] sd);
    @(posedge clk);
    #1;
    load = l; run = r; step = s; rate = rt; seed = sd;
  endtask

  typedef struct packed {
    logic        l, r, s;
    logic [63:0] sd;
    logic [63:0] g;
    logic [15:0] gc;
    logic [1:0]  st;
    logic        ev;
    logic [2:0]  fl;
  } vec_t;

  localparam logic [63:0] B = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] K = 64'h0000_0018_1800_0000;
  localparam logic [63:0] E = 64'h0000_0000_0800_0000;
  localparam logic [63:0] G = 64'h0000_0000_0007_0402;

  vec_t v[22];

  task automatic snap(input string tag, input logic [63:0] g, input logic [15:0] gc, input logic [1:0] st,
                      input logic ev, input logic [2:0] fl);
    chk({tag, ".grid"}, grid, g);
    chk({tag, ".gen_count"}, 64'(gen_count), 64'(gc));
    chk({tag, ".state"}, 64'(state), 64'(st));
    chk({tag, ".evolve"}, 64'(evolve), 64'(ev));
    chk({tag, ".flags"}, 64'({extinct, stable, osc2}), 64'(fl));
  endtask

  initial begin
    v[0]  = '{1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 16'd0, 2'b00, 1'b0, 3'b000};
    v[1]  = '{1'b0, 1'b1, 1'b1, 64'd0, 64'd0, 16'd0, 2'b00, 1'b0, 3'b000};
    v[2]  = '{1'b1, 1'b0, 1'b0, B,     64'd0, 16'd0, 2'b00, 1'b0, 3'b000};
    v[3]  = '{1'b0, 1'b1, 1'b0, 64'd0, B,     16'd0, 2'b01, 1'b0, 3'b000};
    v[4]  = '{1'b0, 1'b1, 1'b0, 64'd0, B,     16'd0, 2'b10, 1'b1, 3'b000};
    v[5]  = '{1'b0, 1'b1, 1'b0, 64'd0, V,     16'd1, 2'b10, 1'b1, 3'b000};
    v[6]  = '{1'b0, 1'b1, 1'b0, 64'd0, B,     16'd2, 2'b11, 1'b0, 3'b001};
    v[7]  = '{1'b0, 1'b1, 1'b1, 64'd0, B,     16'd2, 2'b11, 1'b0, 3'b001};
    v[8]  = '{1'b1, 1'b0, 1'b0, K,     B,     16'd2, 2'b11, 1'b0, 3'b001};
    v[9]  = '{1'b0, 1'b0, 1'b1, 64'd0, K,     16'd0, 2'b01, 1'b1, 3'b000};
    v[10] = '{1'b0, 1'b0, 1'b1, 64'd0, K,     16'd1, 2'b11, 1'b0, 3'b010};
    v[11] = '{1'b0, 1'b1, 1'b0, 64'd0, K,     16'd1, 2'b11, 1'b0, 3'b010};
    v[12] = '{1'b0, 1'b0, 1'b1, 64'd0, K,     16'd1, 2'b11, 1'b0, 3'b010};
    v[13] = '{1'b1, 1'b0, 1'b0, E,     K,     16'd1, 2'b11, 1'b0, 3'b010};
    v[14] = '{1'b1, 1'b0, 1'b1, E,     E,     16'd0, 2'b01, 1'b0, 3'b000};
    v[15] = '{1'b0, 1'b0, 1'b1, 64'd0, E,     16'd0, 2'b01, 1'b0, 3'b000};
    v[16] = '{1'b0, 1'b0, 1'b0, 64'd0, E,     16'd0, 2'b01, 1'b0, 3'b000};
    v[17] = '{1'b0, 1'b0, 1'b1, 64'd0, E,     16'd0, 2'b01, 1'b1, 3'b000};
    for (int i = 18; i < 22; i++)
      v[i] = '{1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 16'd1, 2'b11, 1'b0, 3'b100};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 22; i++) begin
      drive(v[i].l, v[i].r, v[i].s, 4'd0, v[i].sd);
      @(negedge clk);
      snap($sformatf("vec%0d", i), v[i].g, v[i].gc, v[i].st, v[i].ev, v[i].fl);
    end

    // glider at rate 3: one generation every fourth RUNNING cycle
    drive(1'b1, 1'b0, 1'b0, 4'd3, G);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 64'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'd3, 64'd0);
      @(negedge clk);
      chk($sformatf("rate.evolve%0d", i), 64'(evolve), 64'(i % 4 == 3));
      chk($sformatf("rate.state%0d", i), 64'(state), 64'(2'b10));
    end
    drive(1'b0, 1'b0, 1'b0, 4'd3, 64'd0);
    @(negedge clk);
    chk("rate.drop_evolve", 64'(evolve), 64'd0);
    chk("rate.gen_count", 64'(gen_count), 64'd5);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 4'd3, 64'd0);
      @(negedge clk);
      snap($sformatf("paused%0d", i), life(life(life(life(life(G))))), 16'd5, 2'b01, 1'b0, 3'b000);
    end

    // asynchronous reset in the middle of a rate-5 period
    drive(1'b1, 1'b0, 1'b0, 4'd5, G);
    drive(1'b0, 1'b1, 1'b0, 4'd5, 64'd0);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 4'd5, 64'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 snap("reset.async", 64'd0, 16'd0, 2'b00, 1'b0, 3'b000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("reset.held_evolve%0d", i), 64'(evolve), 64'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, i[0], 4'd0, 64'd0);
      @(negedge clk);
      snap($sformatf("idle%0d", i), 64'd0, 16'd0, 2'b00, 1'b0, 3'b000);
    end
    drive(1'b1, 1'b1, 1'b0, 4'd0, B);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 64'd0);
    @(negedge clk);
    snap("reload", B, 16'd0, 2'b01, 1'b0, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
